// File: rtl/vs_dac_pkg.sv
// vs_dac_pkg: shared types and helpers for the DAC serial-audio transmitter.
//   dac_fmt_t   : serial framing, I2S (data one bit clock behind ws) or left-justified
//   dac_ur_t    : behaviour when a frame starts with an empty FIFO
//   dac_level_w : width of a FIFO occupancy counter able to hold 0..depth
package vs_dac_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } dac_fmt_t;

  typedef enum logic {
    UR_ZERO = 1'b0,
    UR_HOLD = 1'b1
  } dac_ur_t;

  function automatic int unsigned dac_level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vs_sync_fifo.sv
// vs_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst_n    : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata   : write request and data; ignored while full
//   pop           : read request; ignored while empty
//   rdata         : head entry, valid whenever empty is low
//   full, empty   : registered status flags
//   level         : registered occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module vs_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_nxt;

  always_comb begin
    do_push   = push && !full;
    do_pop    = pop && !empty;
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
    end
  end

  // Storage needs no reset: entries are only visible once counted in level.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: stereo serial-audio transmitter for the board DAC.
//   clk42_i, res_n_i       : 42 MHz system clock, asynchronous active-low reset
//   en_i                   : serialiser enable; low forces pins to 0 and restarts the frame
//   s_valid_i/s_ready_o    : sample-pair write handshake into the FIFO
//   s_left_i, s_right_i    : two's-complement samples, SAMPLE_W bits each
//   level_o                : FIFO occupancy
//   underrun_o             : sticky, set when a frame starts with an empty FIFO
//   clr_underrun_i         : clears underrun_o (a simultaneous new underrun wins)
//   dac_bck_o/ws_o/data_o  : bit clock, word select (0 = left), serial data MSB first
module dac_i2s_tx
  import vs_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned SLOT_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BCK_DIV    = 7,
  parameter dac_fmt_t    FMT        = FMT_I2S,
  parameter dac_ur_t     UNDERRUN   = UR_ZERO
) (
  input  logic                                 clk42_i,
  input  logic                                 res_n_i,
  input  logic                                 en_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic [SAMPLE_W-1:0]                  s_left_i,
  input  logic [SAMPLE_W-1:0]                  s_right_i,
  output logic [dac_level_w(FIFO_DEPTH)-1:0]   level_o,
  output logic                                 underrun_o,
  input  logic                                 clr_underrun_i,
  output logic                                 dac_bck_o,
  output logic                                 dac_ws_o,
  output logic                                 dac_data_o
);

  localparam int unsigned LVL_W   = dac_level_w(FIFO_DEPTH);
  localparam int unsigned PAIR_W  = 2 * SAMPLE_W;
  localparam int unsigned FRAME_W = 2 * SLOT_W;
  localparam int unsigned DIV_W   = $clog2(BCK_DIV + 1);
  localparam int unsigned BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(BCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] RIGHT_FIRST  = BIT_W'(SLOT_W);

  // Sample sits in the top of the slot; the padding below it is zero.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [SAMPLE_W-1:0] s);
    return SLOT_W'(s) << (SLOT_W - SAMPLE_W);
  endfunction

  logic [DIV_W-1:0]    div_cnt;
  logic                bck;
  logic [BIT_W-1:0]    bit_cnt;
  logic                ws;
  logic                data;
  logic                lj_bit;   // bit as it would appear in left-justified framing
  logic [FRAME_W-1:0]  sr;
  logic [SAMPLE_W-1:0] held_l;
  logic [SAMPLE_W-1:0] held_r;
  logic                underrun;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [PAIR_W-1:0]   fifo_rdata;

  logic                div_tc;
  logic                fall_tick;
  logic                wrap;
  logic                ur_set;
  logic [BIT_W-1:0]    bit_nxt;
  logic [SAMPLE_W-1:0] ld_l;
  logic [SAMPLE_W-1:0] ld_r;
  logic [FRAME_W-1:0]  frame;
  logic [FRAME_W-1:0]  sr_nxt;
  logic                lj_nxt;
  logic                data_nxt;
  logic                ws_nxt;

  vs_sync_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk42_i),
    .rst_n (res_n_i),
    .push  (s_valid_i),
    .wdata ({s_left_i, s_right_i}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_comb begin
    div_tc    = en_i && (div_cnt == DIV_LAST);
    fall_tick = div_tc && bck;
    wrap      = fall_tick && (bit_cnt == BIT_LAST);
    bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    fifo_pop  = wrap && !fifo_empty;
    ur_set    = wrap && fifo_empty;

    ld_l = '0;
    ld_r = '0;
    if (!fifo_empty) begin
      {ld_l, ld_r} = fifo_rdata;
    end else if (UNDERRUN == UR_HOLD) begin
      ld_l = held_l;
      ld_r = held_r;
    end
    frame = {to_slot(ld_l), to_slot(ld_r)};

    if (wrap) begin
      lj_nxt = frame[FRAME_W-1];
      sr_nxt = {frame[FRAME_W-2:0], 1'b0};
    end else begin
      lj_nxt = sr[FRAME_W-1];
      sr_nxt = {sr[FRAME_W-2:0], 1'b0};
    end

    // I2S sends the previous bit slot's value, giving the one-bit-clock lag.
    data_nxt = (FMT == FMT_LJ) ? lj_nxt : lj_bit;
    ws_nxt   = (bit_nxt >= RIGHT_FIRST);
  end

  always_ff @(posedge clk42_i or negedge res_n_i) begin
    if (!res_n_i) begin
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= '0;
      ws      <= 1'b0;
      data    <= 1'b0;
      lj_bit  <= 1'b0;
      sr      <= '0;
    end else if (!en_i) begin
      // Clearing the shift register makes the first frame after enable silent.
      div_cnt <= '0;
      bck     <= 1'b0;
      bit_cnt <= '0;
      ws      <= 1'b0;
      data    <= 1'b0;
      lj_bit  <= 1'b0;
      sr      <= '0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
      if (div_tc) begin
        bck <= ~bck;
      end
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        ws      <= ws_nxt;
        lj_bit  <= lj_nxt;
        data    <= data_nxt;
        sr      <= sr_nxt;
      end
    end
  end

  // Held pair and underrun flag survive en_i low; only reset clears them.
  always_ff @(posedge clk42_i or negedge res_n_i) begin
    if (!res_n_i) begin
      held_l   <= '0;
      held_r   <= '0;
      underrun <= 1'b0;
    end else begin
      if (fifo_pop) begin
        {held_l, held_r} <= fifo_rdata;
      end
      if (ur_set) begin
        underrun <= 1'b1;
      end else if (clr_underrun_i) begin
        underrun <= 1'b0;
      end
    end
  end

  assign s_ready_o  = ~fifo_full;
  assign underrun_o = underrun;
  assign dac_bck_o  = bck;
  assign dac_ws_o   = ws;
  assign dac_data_o = data;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// tb_dac_i2s_tx: directed bench for dac_i2s_tx. Three instances share clock,
// reset, enable and handshake: a = LJ/zero-fill, b = I2S/hold, c = LJ with
// 12-bit samples in 16-bit slots. Serial data is captured on bit-clock rises.
module tb_dac_i2s_tx;
  import vs_dac_pkg::*;

  logic        clk;
  logic        res_n;
  logic        en;
  logic        valid;
  logic        clr;
  logic [15:0] left;
  logic [15:0] right;
  logic [11:0] pleft;
  logic [11:0] pright;

  logic       a_ready, b_ready, c_ready;
  logic [2:0] a_level, b_level, c_level;
  logic       a_underrun, b_underrun, c_underrun;
  logic       a_bck, b_bck, c_bck;
  logic       a_ws, b_ws, c_ws;
  logic       a_data, b_data, c_data;

  dac_i2s_tx #(
    .SAMPLE_W(16), .SLOT_W(16), .FIFO_DEPTH(4), .BCK_DIV(2),
    .FMT(FMT_LJ), .UNDERRUN(UR_ZERO)
  ) u_a (
    .clk42_i(clk), .res_n_i(res_n), .en_i(en), .s_valid_i(valid),
    .s_ready_o(a_ready), .s_left_i(left), .s_right_i(right),
    .level_o(a_level), .underrun_o(a_underrun), .clr_underrun_i(clr),
    .dac_bck_o(a_bck), .dac_ws_o(a_ws), .dac_data_o(a_data)
  );

  dac_i2s_tx #(
    .SAMPLE_W(16), .SLOT_W(16), .FIFO_DEPTH(4), .BCK_DIV(2),
    .FMT(FMT_I2S), .UNDERRUN(UR_HOLD)
  ) u_b (
    .clk42_i(clk), .res_n_i(res_n), .en_i(en), .s_valid_i(valid),
    .s_ready_o(b_ready), .s_left_i(left), .s_right_i(right),
    .level_o(b_level), .underrun_o(b_underrun), .clr_underrun_i(clr),
    .dac_bck_o(b_bck), .dac_ws_o(b_ws), .dac_data_o(b_data)
  );

  dac_i2s_tx #(
    .SAMPLE_W(12), .SLOT_W(16), .FIFO_DEPTH(4), .BCK_DIV(2),
    .FMT(FMT_LJ), .UNDERRUN(UR_ZERO)
  ) u_c (
    .clk42_i(clk), .res_n_i(res_n), .en_i(en), .s_valid_i(valid),
    .s_ready_o(c_ready), .s_left_i(pleft), .s_right_i(pright),
    .level_o(c_level), .underrun_o(c_underrun), .clr_underrun_i(clr),
    .dac_bck_o(c_bck), .dac_ws_o(c_ws), .dac_data_o(c_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        last_bck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Waits for the next bit-clock rise, sampling 1 time unit after each clock edge.
  task automatic next_rise(output int unsigned gap);
    logic found;
    found = 1'b0;
    gap   = 0;
    while (!found && gap <= 64) begin
      @(posedge clk);
      #1;
      gap++;
      if (a_bck && !last_bck) found = 1'b1;
      last_bck = a_bck;
    end
    if (!found) chk("bck_rise_timeout", {31'd0, a_bck}, 32'd1);
  endtask

  task automatic read_frame(output logic [31:0] lj, output logic [31:0] i2s,
                            output logic [31:0] pad, output logic [31:0] ws,
                            output logic rdy0, output logic rdy31, output logic ur0,
                            output logic [2:0] lvl0, output int unsigned gap);
    lj = '0; i2s = '0; pad = '0; ws = '0;
    rdy0 = 1'b0; rdy31 = 1'b0; ur0 = 1'b0; lvl0 = '0; gap = 0;
    for (int i = 0; i < 32; i++) begin
      next_rise(gap);
      lj  = {lj[30:0],  a_data};
      i2s = {i2s[30:0], b_data};
      pad = {pad[30:0], c_data};
      ws  = {ws[30:0],  a_ws};
      if (i == 0) begin
        rdy0 = a_ready;
        ur0  = a_underrun;
        lvl0 = a_level;
      end
      if (i == 31) rdy31 = a_ready;
    end
  endtask

  task automatic drive_pair(input logic [15:0] l, input logic [15:0] r,
                            input logic [11:0] pl, input logic [11:0] pr);
    @(negedge clk);
    valid  = 1'b1;
    left   = l;
    right  = r;
    pleft  = pl;
    pright = pr;
  endtask

  logic [31:0] f_lj, f_i2s, f_pad, f_ws;
  logic        f_rdy0, f_rdy31, f_ur0;
  logic [2:0]  f_lvl0;
  int unsigned f_gap;

  // Expected per-frame data for frames 1..4 after the first enable.
  logic [31:0] exp_lj  [4] = '{32'hA5F00F0F, 32'h12348001, 32'hFFFF0000, 32'h00018000};
  logic [31:0] exp_i2s [4] = '{32'h52F80787, 32'h891A4000, 32'hFFFF8000, 32'h0000C000};
  logic [31:0] exp_pad [4] = '{32'h80008000, 32'hFFF00010, 32'h12304560, 32'h00108000};

  initial begin
    res_n = 1'b0; en = 1'b0; valid = 1'b0; clr = 1'b0;
    left = '0; right = '0; pleft = '0; pright = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bck",      {31'd0, a_bck},      32'd0);
    chk("rst_ws",       {31'd0, a_ws},       32'd0);
    chk("rst_data",     {31'd0, a_data},     32'd0);
    chk("rst_ready",    {31'd0, a_ready},    32'd1);
    chk("rst_level",    {29'd0, a_level},    32'd0);
    chk("rst_underrun", {31'd0, a_underrun}, 32'd0);

    @(negedge clk);
    res_n = 1'b1;

    // Fill the depth-4 FIFO while disabled, then try a fifth write.
    drive_pair(16'hA5F0, 16'h0F0F, 12'h800, 12'h800);
    drive_pair(16'h1234, 16'h8001, 12'hFFF, 12'h001);
    chk("level_after_1", {29'd0, a_level}, 32'd1);
    drive_pair(16'hFFFF, 16'h0000, 12'h123, 12'h456);
    drive_pair(16'h0001, 16'h8000, 12'h001, 12'h800);
    drive_pair(16'h5555, 16'h5555, 12'h555, 12'h555);
    chk("full_ready", {31'd0, a_ready}, 32'd0);
    chk("full_level", {29'd0, a_level}, 32'd4);
    @(negedge clk);
    chk("refused_level", {29'd0, a_level}, 32'd4);
    chk("refused_ready", {31'd0, b_ready}, 32'd0);
    valid    = 1'b0;
    en       = 1'b1;
    last_bck = 1'b0;

    // Silent first frame.
    read_frame(f_lj, f_i2s, f_pad, f_ws, f_rdy0, f_rdy31, f_ur0, f_lvl0, f_gap);
    chk("f0_lj",     f_lj,  32'h0);
    chk("f0_i2s",    f_i2s, 32'h0);
    chk("f0_pad",    f_pad, 32'h0);
    chk("f0_ws",     f_ws,  32'h0000FFFF);
    chk("f0_lvl",    {29'd0, f_lvl0}, 32'd4);
    chk("f0_rdy_end", {31'd0, f_rdy31}, 32'd0);
    chk("bck_period", f_gap, 32'd4);

    for (int f = 0; f < 4; f++) begin
      read_frame(f_lj, f_i2s, f_pad, f_ws, f_rdy0, f_rdy31, f_ur0, f_lvl0, f_gap);
      chk($sformatf("f%0d_lj",  f + 1), f_lj,  exp_lj[f]);
      chk($sformatf("f%0d_i2s", f + 1), f_i2s, exp_i2s[f]);
      chk($sformatf("f%0d_pad", f + 1), f_pad, exp_pad[f]);
      chk($sformatf("f%0d_ws",  f + 1), f_ws,  32'h0000FFFF);
      chk($sformatf("f%0d_lvl", f + 1), {29'd0, f_lvl0}, 32'(3 - f));
      chk($sformatf("f%0d_ur",  f + 1), {31'd0, f_ur0},  32'd0);
      if (f == 0) chk("pop_ready", {31'd0, f_rdy0}, 32'd1);
    end

    // FIFO now empty: zero-fill versus hold, sticky flag.
    read_frame(f_lj, f_i2s, f_pad, f_ws, f_rdy0, f_rdy31, f_ur0, f_lvl0, f_gap);
    chk("f5_lj_zero",  f_lj,  32'h0);
    chk("f5_i2s_hold", f_i2s, 32'h0000C000);
    chk("f5_pad_zero", f_pad, 32'h0);
    chk("f5_ur",       {31'd0, f_ur0}, 32'd1);

    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("ur_cleared", {31'd0, a_underrun}, 32'd0);
    clr      = 1'b0;
    last_bck = a_bck;

    read_frame(f_lj, f_i2s, f_pad, f_ws, f_rdy0, f_rdy31, f_ur0, f_lvl0, f_gap);
    chk("f6_ur_reset", {31'd0, f_ur0}, 32'd1);
    chk("f6_i2s_hold", f_i2s, 32'h0000C000);
    chk("f6_lj_zero",  f_lj,  32'h0);

    // Land mid right slot with one entry queued, then pull reset.
    repeat (4) @(posedge clk);
    drive_pair(16'h1111, 16'h2222, 12'h111, 12'h222);
    @(negedge clk);
    valid = 1'b0;
    repeat (71) @(posedge clk);
    #1;
    chk("pre_rst_level", {29'd0, a_level},    32'd1);
    chk("pre_rst_ws",    {31'd0, a_ws},       32'd1);
    chk("pre_rst_bck",   {31'd0, a_bck},      32'd1);
    chk("pre_rst_ur",    {31'd0, a_underrun}, 32'd1);
    #2;
    res_n = 1'b0;
    #1;
    chk("mid_rst_bck",   {31'd0, a_bck},      32'd0);
    chk("mid_rst_ws",    {31'd0, a_ws},       32'd0);
    chk("mid_rst_data",  {31'd0, b_data},     32'd0);
    chk("mid_rst_level", {29'd0, a_level},    32'd0);
    chk("mid_rst_ur",    {31'd0, a_underrun}, 32'd0);
    chk("mid_rst_ready", {31'd0, a_ready},    32'd1);

    @(negedge clk);
    res_n    = 1'b1;
    valid    = 1'b1;
    left     = 16'hC3C3;
    right    = 16'h3C3C;
    pleft    = 12'hC3C;
    pright   = 12'h3C3;
    last_bck = 1'b0;
    @(negedge clk);
    valid = 1'b0;

    read_frame(f_lj, f_i2s, f_pad, f_ws, f_rdy0, f_rdy31, f_ur0, f_lvl0, f_gap);
    chk("r0_lj_silent",  f_lj,  32'h0);
    chk("r0_i2s_silent", f_i2s, 32'h0);
    chk("r0_ws",         f_ws,  32'h0000FFFF);
    read_frame(f_lj, f_i2s, f_pad, f_ws, f_rdy0, f_rdy31, f_ur0, f_lvl0, f_gap);
    chk("r1_lj",  f_lj,  32'hC3C33C3C);
    chk("r1_i2s", f_i2s, 32'h61E19E1E);
    chk("r1_pad", f_pad, 32'hC3C03C30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dac_i2s_tx.md
# dac_i2s_tx

Parametrised stereo serial-audio transmitter driving the board DAC pins (`dac_bck_o`, `dac_ws_o`, `dac_data_o`) from the 42 MHz system clock. Sound sources push left/right sample pairs through a valid/ready port into an internal FIFO. The block serialises each pair MSB-first in either I2S or left-justified format, with programmable sample width, slot width and bit-clock divider. It sits beside `video` under the top level and replaces the hard-wired DAC tie-offs.

## Interface
- `SAMPLE_W`, 16: bits per channel sample, range 8..24.
- `SLOT_W`, 16: bit-clock periods per channel slot; must satisfy SAMPLE_W ≤ SLOT_W ≤ 32.
- `FIFO_DEPTH`, 8: sample-pair entries; power of two, ≥ 2.
- `BCK_DIV`, 7: clk42 cycles per bit-clock half period; ≥ 1.
- `FMT`, FMT_I2S: `dac_fmt_t`; FMT_I2S or FMT_LJ.
- `UNDERRUN`, UR_ZERO: `dac_ur_t`; UR_ZERO sends zeros, UR_HOLD repeats the last pair.

Ports:
- `clk42_i` in 1: system clock, 42 MHz.
- `res_n_i` in 1: asynchronous active-low reset.
- `en_i` in 1: serialiser enable.
- `s_valid_i` in 1: sample pair valid.
- `s_ready_o` out 1: FIFO not full.
- `s_left_i` in SAMPLE_W: left sample, two's complement.
- `s_right_i` in SAMPLE_W: right sample.
- `level_o` out $clog2(FIFO_DEPTH+1): FIFO occupancy.
- `underrun_o` out 1: sticky underrun flag.
- `clr_underrun_i` in 1: clears `underrun_o`.
- `dac_bck_o`, `dac_ws_o`, `dac_data_o` out 1 each: serial bit clock, word select (0 = left), and data.

## Operation
- Reset values: bck=0, ws=0, data=0, `s_ready_o`=1, `level_o`=0, `underrun_o`=0. FIFO is emptied and the held pair is zeroed.
- A write is accepted on any clock where `s_valid_i` and `s_ready_o` are both high.
- `s_ready_o` depends only on registered full. A write is refused when the FIFO is full, even if a pop happens in the same clock.
- Divider: when `en_i`=1, it counts 0..BCK_DIV-1 and toggles bck on terminal count.
  - A "fall tick" is a clock where bck goes 1→0.
  - Bit counter `bitcnt` runs 0..2·SLOT_W-1 and advances on each fall tick.
- Frame load: on the fall tick where `bitcnt` wraps to 0, pop one pair from the FIFO into the shift register.
  - If the FIFO is empty, load zeros (UR_ZERO) or the previous pair (UR_HOLD), and set `underrun_o`.
- Slot layout: sample bits occupy the top SAMPLE_W bits of the slot, MSB first. The remaining SLOT_W−SAMPLE_W bits are 0.
- ws = 1 while `bitcnt` ≥ SLOT_W. ws and data change only on fall ticks.
- FMT_LJ: the left MSB is driven on the fall tick where `bitcnt` becomes 0.
- FMT_I2S: data is delayed by one bit-clock relative to ws.
  - The left MSB appears at `bitcnt`=1.
  - At `bitcnt`=0 the output carries the LSB of the previous right slot (0 after reset or enable).
- `en_i`=0: bck, ws and data are forced to 0, and the divider and `bitcnt` are cleared. The FIFO still accepts writes and keeps its contents, and the held pair is kept.
- `en_i` rise: the first frame is the pair loaded by the first wrap, so the block outputs one silent frame first.
- If `clr_underrun_i` and a new underrun occur in the same clock, set wins.
- Asynchronous reset mid-frame returns every output to its reset value immediately. There is no partial-frame completion.

## Timing
- Bit clock frequency = 42 MHz / (2·BCK_DIV). Frame = 2·SLOT_W bit clocks.
- FIFO is first-word-fall-through: a pair written into an empty FIFO is poppable on the next clock.
- `level_o` updates one clock after the write or pop.
- `underrun_o` rises one clock after the empty load.
- Pins are driven directly from flops, with no combinational path to the outputs.

## Structure
- Package `vs_dac_pkg`:
  - enums `dac_fmt_t` {FMT_I2S, FMT_LJ} and `dac_ur_t` {UR_ZERO, UR_HOLD};
  - localparam function computing the level width.
- Sub-module `vs_sync_fifo`: parametrised width and depth, FWFT, registered full/empty and level. It is reusable by other audio sources.
- The remaining logic (divider, bit counter, shift/load, flag) lives in `dac_i2s_tx`, with about 200 lines total.

## Test plan
- SAMPLE_W=SLOT_W=16, BCK_DIV=2, FMT_LJ: write L=0xA5F0, R=0x0F0F, then enable.
  - After the silent frame, data reads 1010010111110000 with ws=0, then 0000111100001111 with ws=1.
  - bck period is 4 clocks.
- Same stimulus with FMT_I2S: the MSB of 0xA5F0 lands one bit clock after ws falls, and R's LSB=1 appears at the next frame's `bitcnt`=0.
- SAMPLE_W=12, SLOT_W=16, L=0x800: each slot reads 1000_0000_0000_0000, confirming the padding zeros.
- FIFO_DEPTH=4, `en_i`=0: write 5 pairs back-to-back.
  - 4 are accepted, `level_o`=4, and `s_ready_o`=0 on the 5th.
  - After enable, one pop raises `s_ready_o` the next clock.
- Empty FIFO with UR_ZERO: all frames output zeros and `underrun_o`=1.
  - `clr_underrun_i` clears the flag, and it re-sets at the next empty wrap.
  - With UR_HOLD, the last pair repeats.
- Assert `res_n_i` low mid-slot: bck/ws/data go to 0 that clock, `level_o`=0, and a released enable restarts with a silent frame.
